fir_serial_ctrl: RTL and testbench

Sequencer for a time-multiplexed (single-MAC) symmetric-or-arbitrary FIR filter: accepts one sample per handshake, steps one shared multiply-accumulate through all taps over a circular delay line, then rounds, shifts and saturates to the output width. It replaces the fully parallel `fir_sync` datapath where area matters more than throughput. It also owns the runtime-writable coefficient register file.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_serial_ctrl_if.sv | 31 +++
 rtl/fir_mac.sv | 35 +++
 rtl/fir_serial_ctrl.sv | 140 ++++++++++++++
 tb/tb_fir_serial_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the serial (single-MAC) FIR sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned TAPS_DEF  = 16;
  localparam int unsigned DW_DEF    = 10;
  localparam int unsigned CW_DEF    = 8;
  localparam int unsigned OW_DEF    = 11;
  localparam int unsigned SHIFT_DEF = 6;

  // Tap 0 sits in the least significant CW bits; taps listed 15 down to 0.
  localparam logic [TAPS_DEF*CW_DEF-1:0] COEF_INIT_DEF = {
    8'h00, 8'h00, 8'h01, 8'hFE, 8'h02, 8'h00, 8'hF9, 8'h26,
    8'h26, 8'hF9, 8'h00, 8'h02, 8'hFE, 8'h01, 8'h00, 8'h00
  };

  // Accumulator wide enough that TAPS full-scale products never overflow.
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned cw,
                                            input int unsigned taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_serial_ctrl_if.sv
// Sample/coefficient/result bus between a host and fir_serial_ctrl.
interface fir_serial_ctrl_if #(
  parameter int unsigned TAPS = 16,
  parameter int unsigned DW   = 10,
  parameter int unsigned CW   = 8,
  parameter int unsigned OW   = 11
);
  localparam int unsigned PW = $clog2(TAPS);

  logic                 din_valid;
  logic                 din_ready;
  logic signed [DW-1:0] din;
  logic                 coef_we;
  logic [PW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_err;
  logic                 dout_valid;
  logic signed [OW-1:0] dout;
  logic                 busy;

  modport master (
    output din_valid, din, coef_we, coef_addr, coef_data,
    input  din_ready, coef_err, dout_valid, dout, busy
  );

  modport slave (
    input  din_valid, din, coef_we, coef_addr, coef_data,
    output din_ready, coef_err, dout_valid, dout, busy
  );

endinterface

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear; one product per enabled cycle.
module fir_mac #(
  parameter int unsigned DW = 10,
  parameter int unsigned CW = 8,
  parameter int unsigned AW = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [CW-1:0] c_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int unsigned PRW = DW + CW;

  logic signed [PRW-1:0] prod_c;
  logic signed [AW-1:0]  acc_q;

  assign prod_c = PRW'(x_i) * PRW'(c_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + AW'(prod_c);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed FIR sequencer: circular delay line, writable coefficients, one shared MAC.
// Define FIR_CTRL_SAT_EN to saturate the output; otherwise it wraps to OW bits.
module fir_serial_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned OW    = OW_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF,
  parameter logic [TAPS*CW-1:0] COEF_INIT = COEF_INIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  fir_serial_ctrl_if.slave   bus
);

  localparam int unsigned PW = $clog2(TAPS);
  localparam int unsigned AW = acc_width(DW, CW, TAPS);
  localparam logic signed [AW-1:0] RND = AW'(2 ** (SHIFT - 1));
`ifdef FIR_CTRL_SAT_EN
  localparam logic signed [AW-1:0] OMAX = AW'((2 ** (OW - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (OW - 1)));
`endif

  state_e               state_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        k_q;
  logic signed [DW-1:0] dline_q [TAPS];
  logic signed [CW-1:0] coef_q  [TAPS];
  logic signed [OW-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 coef_err_q;
  logic                 busy_q;
  logic                 din_ready_q;

  logic                 accept_c;
  logic                 mac_en_c;
  logic [PW-1:0]        rd_idx_c;
  logic signed [AW-1:0] acc_c;
  logic signed [AW-1:0] rnd_c;
  logic signed [AW-1:0] shr_c;
  logic signed [OW-1:0] y_c;

  assign accept_c = (state_q == ST_IDLE) && bus.din_valid;
  assign mac_en_c = (state_q == ST_MAC);
  // Newest sample lives at wr_ptr; tap k reaches k samples back.
  assign rd_idx_c = wr_ptr_q - k_q;

  fir_mac #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept_c),
    .en_i  (mac_en_c),
    .x_i   (dline_q[rd_idx_c]),
    .c_i   (coef_q[k_q]),
    .acc_o (acc_c)
  );

  assign rnd_c = acc_c + RND;
  assign shr_c = rnd_c >>> SHIFT;

  always_comb begin
    y_c = OW'(shr_c);
`ifdef FIR_CTRL_SAT_EN
    if (shr_c > OMAX) begin
      y_c = OW'(OMAX);
    end else if (shr_c < OMIN) begin
      y_c = OW'(OMIN);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      k_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      coef_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b1;
      for (int i = 0; i < int'(TAPS); i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= COEF_INIT[i*CW +: CW];
      end
    end else begin
      dout_valid_q <= 1'b0;
      coef_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Write lands on the same edge as an accept, so that sample sees it.
          if (bus.coef_we) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
          end
          if (bus.din_valid) begin
            dline_q[wr_ptr_q] <= bus.din;
            k_q               <= '0;
            state_q           <= ST_MAC;
            din_ready_q       <= 1'b0;
            busy_q            <= 1'b1;
          end
        end
        ST_MAC: begin
          coef_err_q <= bus.coef_we;
          k_q        <= k_q + PW'(1);
          if (k_q == PW'(TAPS - 1)) begin
            state_q  <= ST_DONE;
            wr_ptr_q <= wr_ptr_q + PW'(1);
          end
        end
        ST_DONE: begin
          coef_err_q   <= bus.coef_we;
          dout_q       <= y_c;
          dout_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
          din_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          din_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.coef_err   = coef_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Directed self-checking bench for fir_serial_ctrl (default parameters).
module tb_fir_serial_ctrl;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fir_serial_ctrl_if #(.TAPS(16), .DW(10), .CW(8), .OW(11)) bus ();

  fir_serial_ctrl #(
    .TAPS (16),
    .DW   (10),
    .CW   (8),
    .OW   (11),
    .SHIFT(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int exp_imp [17] = '{0, 0, 8, -16, 16, 0, -56, 303, 303, -56, 0, 16, -16, 8, 0, 0, 0};

`ifdef FIR_CTRL_SAT_EN
  localparam int SAT_Y2  = 1023;
  localparam int SAT_Y16 = 1023;
`else
  localparam int SAT_Y2  = -20;
  localparam int SAT_Y16 = -160;
`endif

  // Called at a negedge; returns at the negedge where dout_valid is seen.
  task automatic send(input int val, output int y, output int lat, output bit to);
    int n;
    to  = 1'b0;
    y   = 0;
    lat = 0;
    n   = 0;
    while (bus.din_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.din_ready !== 1'b1) begin
      to = 1'b1;
      return;
    end
    bus.din_valid = 1'b1;
    bus.din       = 10'(val);
    @(negedge clk);
    bus.din_valid = 1'b0;
    while (bus.dout_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.dout_valid !== 1'b1) to = 1'b1;
    y = int'(bus.dout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 8'(data);
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.din_ready); end
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); end
    checks++;
    if (bus.dout !== 11'sd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", bus.dout); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.coef_err !== 1'b0) begin errors++; $display("FAIL reset_coef_err: got %b expected 0", bus.coef_err); end
  endtask

  task automatic test_impulse();
    int y, lat;
    bit to;
    do_reset();
    for (int n = 0; n < 17; n++) begin
      send((n == 0) ? 511 : 0, y, lat, to);
      checks++;
      if (to || y !== exp_imp[n]) begin
        errors++;
        $display("FAIL impulse_y%0d: got %0d (timeout %0b) expected %0d", n, y, to, exp_imp[n]);
      end
      if (n == 0) begin
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL impulse_latency: got %0d expected 17", lat); end
      end
    end
  endtask

  task automatic test_back_to_back_dc();
    int acc_cyc [20];
    int out_cyc [20];
    int out_val [20];
    int na, no;
    do_reset();
    na = 0;
    no = 0;
    bus.din         = 10'sd511;
    bus.din_valid   = 1'b1;
    for (int c = 0; c < 420 && no < 20; c++) begin
      if (na >= 20) bus.din_valid = 1'b0;
      if (bus.dout_valid === 1'b1) begin
        out_cyc[no] = c;
        out_val[no] = int'(bus.dout);
        no++;
      end
      if (bus.din_valid === 1'b1 && bus.din_ready === 1'b1) begin
        acc_cyc[na] = c;
        na++;
      end
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    checks++;
    if (na !== 20 || no !== 20) begin
      errors++;
      $display("FAIL dc_counts: got accepts %0d outputs %0d expected 20 20", na, no);
    end else begin
      for (int i = 1; i < 20; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 18) begin
          errors++;
          $display("FAIL dc_period%0d: got %0d expected 18", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
      // Accept edge follows negedge c; dout seen at the negedge 17 edges later.
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (out_cyc[i] - acc_cyc[i] !== 18) begin
          errors++;
          $display("FAIL dc_latency%0d: got %0d expected 18", i, out_cyc[i] - acc_cyc[i]);
        end
      end
      for (int i = 15; i < 20; i++) begin
        checks++;
        if (out_val[i] !== 511) begin
          errors++;
          $display("FAIL dc_y%0d: got %0d expected 511", i, out_val[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int y, lat;
    bit to;
    do_reset();
    for (int a = 0; a < 16; a++) write_coef(a, 127);
    for (int n = 0; n < 16; n++) begin
      send(511, y, lat, to);
      if (n == 0) begin
        checks++;
        if (to || y !== 1014) begin errors++; $display("FAIL sat_y1: got %0d (timeout %0b) expected 1014", y, to); end
      end
      if (n == 1) begin
        checks++;
        if (to || y !== SAT_Y2) begin errors++; $display("FAIL sat_y2: got %0d (timeout %0b) expected %0d", y, to, SAT_Y2); end
      end
      if (n == 15) begin
        checks++;
        if (to || y !== SAT_Y16) begin errors++; $display("FAIL sat_y16: got %0d (timeout %0b) expected %0d", y, to, SAT_Y16); end
      end
    end
  endtask

  task automatic test_rejected_write();
    int y, lat, w;
    bit to;
    do_reset();
    bus.din       = 10'sd511;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.din_ready !== 1'b0) begin
      errors++;
      $display("FAIL rej_mac_flags: got busy %b ready %b expected 1 0", bus.busy, bus.din_ready);
    end
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd7;
    bus.coef_data = 8'sd0;
    @(negedge clk);
    bus.coef_we = 1'b0;
    checks++;
    if (bus.coef_err !== 1'b1) begin errors++; $display("FAIL rej_err_pulse: got %b expected 1", bus.coef_err); end
    @(negedge clk);
    checks++;
    if (bus.coef_err !== 1'b0) begin errors++; $display("FAIL rej_err_clear: got %b expected 0", bus.coef_err); end
    w = 0;
    while (bus.dout_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 11'sd0) begin
      errors++;
      $display("FAIL rej_y0: got %0d valid %b expected 0 valid 1", bus.dout, bus.dout_valid);
    end
    for (int n = 1; n < 8; n++) begin
      send(0, y, lat, to);
      if (n == 6) begin
        checks++;
        if (to || y !== -56) begin errors++; $display("FAIL rej_y6: got %0d (timeout %0b) expected -56", y, to); end
      end
      if (n == 7) begin
        checks++;
        if (to || y !== 303) begin errors++; $display("FAIL rej_y7: got %0d (timeout %0b) expected 303", y, to); end
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int y, lat, pulses;
    bit to;
    do_reset();
    for (int n = 0; n < 3; n++) send(0, y, lat, to);
    bus.din       = 10'sd511;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: got ready %b busy %b valid %b expected 1 0 0",
               bus.din_ready, bus.busy, bus.dout_valid);
    end
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.dout_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_output: got %0d pulses expected 0", pulses); end
    for (int n = 0; n < 17; n++) begin
      send((n == 0) ? 511 : 0, y, lat, to);
      checks++;
      if (to || y !== exp_imp[n]) begin
        errors++;
        $display("FAIL midrst_y%0d: got %0d (timeout %0b) expected %0d", n, y, to, exp_imp[n]);
      end
    end
  endtask

  task automatic test_collision();
    int w;
    do_reset();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'sd64;
    bus.din       = 10'sd100;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.coef_we   = 1'b0;
    bus.din_valid = 1'b0;
    w = 0;
    while (bus.dout_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 11'sd100) begin
      errors++;
      $display("FAIL collision_y: got %0d valid %b expected 100 valid 1", bus.dout, bus.dout_valid);
    end
  endtask

  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    test_reset();
    test_impulse();
    test_back_to_back_dc();
    test_rejected_write();
    test_reset_mid_mac();
    test_collision();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
